// File: rtl/cpu_register_file_mp.sv
// Multi-port register file with write bypass, prioritised writeback ports,
// a busy scoreboard and a sequential one-register-per-cycle clear engine.
module cpu_register_file_mp #(
  parameter int DATA_WIDTH           = 8,
  parameter int NUMBER_OF_REGISTERS  = 16,
  parameter int NUMBER_OF_READ_PORTS = 2,
  localparam int AW = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                                       clock_in,
  input  logic                                       reset_in,
  input  logic [NUMBER_OF_READ_PORTS*AW-1:0]         read_address_in,
  output logic [NUMBER_OF_READ_PORTS*DATA_WIDTH-1:0] read_data_out,
  output logic [NUMBER_OF_READ_PORTS-1:0]            read_busy_out,
  input  logic                                       write0_enable_in,
  input  logic [AW-1:0]                              write0_address_in,
  input  logic signed [DATA_WIDTH-1:0]               write0_data_in,
  input  logic                                       write1_enable_in,
  input  logic [AW-1:0]                              write1_address_in,
  input  logic signed [DATA_WIDTH-1:0]               write1_data_in,
  input  logic                                       reserve_enable_in,
  input  logic [AW-1:0]                              reserve_address_in,
  input  logic                                       clear_start_in,
  output logic                                       clear_busy_out,
  output logic                                       clear_done_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [AW-1:0] LAST_INDEX = AW'(NUMBER_OF_REGISTERS - 1);

  logic [1:0]                   r_state;
  logic [AW-1:0]                r_index;
  logic signed [DATA_WIDTH-1:0] r_regs [NUMBER_OF_REGISTERS];
  logic [NUMBER_OF_REGISTERS-1:0] r_busy;

  logic w_idle;
  logic w_wr0;
  logic w_wr1;
  logic w_rsv;

  // Reset is folded in so bypassed data also reads as zero while reset is held.
  assign w_idle = (r_state == S_IDLE) && !reset_in;
  assign w_wr0  = write0_enable_in && (write0_address_in != '0) && w_idle;
  assign w_wr1  = write1_enable_in && (write1_address_in != '0) && w_idle &&
                  !(w_wr0 && (write1_address_in == write0_address_in));
  assign w_rsv  = reserve_enable_in && (reserve_address_in != '0) && w_idle;

  assign clear_busy_out = (r_state != S_IDLE);
  assign clear_done_out = (r_state == S_DONE);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy  <= '0;
      r_state <= S_IDLE;
      r_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr0) begin
            r_regs[write0_address_in] <= write0_data_in;
            r_busy[write0_address_in] <= 1'b0;
          end
          if (w_wr1) begin
            r_regs[write1_address_in] <= write1_data_in;
            r_busy[write1_address_in] <= 1'b0;
          end
          // Placed after the writes so a same-cycle reserve leaves the bit set.
          if (w_rsv) begin
            r_busy[reserve_address_in] <= 1'b1;
          end
          if (clear_start_in) begin
            r_state <= S_CLEAR;
            r_index <= AW'(1);
          end
        end
        S_CLEAR: begin
          r_regs[r_index] <= '0;
          r_busy[r_index] <= 1'b0;
          if (r_index == LAST_INDEX) begin
            r_state <= S_DONE;
          end else begin
            r_index <= r_index + AW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar p = 0; p < NUMBER_OF_READ_PORTS; p++) begin : g_read
    logic [AW-1:0]                w_ra;
    logic signed [DATA_WIDTH-1:0] w_rd;

    assign w_ra = read_address_in[p*AW +: AW];

    always_comb begin
      w_rd = r_regs[w_ra];
      if (w_ra == '0) begin
        w_rd = '0;
      end else if (w_wr0 && (write0_address_in == w_ra)) begin
        w_rd = write0_data_in;
      end else if (w_wr1 && (write1_address_in == w_ra)) begin
        w_rd = write1_data_in;
      end
    end

    assign read_data_out[p*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign read_busy_out[p] = r_busy[w_ra];
  end

endmodule

// File: tb/tb_cpu_register_file_mp.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model, and a wider parameter set on a second instance.
module tb_cpu_register_file_mp;

  localparam int DW = 8;
  localparam int N  = 16;
  localparam int P  = 2;
  localparam int AW = 4;

  localparam int DW2 = 16;
  localparam int N2  = 32;
  localparam int P2  = 3;
  localparam int AW2 = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [P*AW-1:0]  a_raddr;
  logic [P*DW-1:0]  a_rdata;
  logic [P-1:0]     a_rbusy;
  logic             a_w0_en, a_w1_en, a_rsv_en, a_clr_start, a_clr_busy, a_clr_done;
  logic [AW-1:0]    a_w0_addr, a_w1_addr, a_rsv_addr;
  logic [DW-1:0]    a_w0_data, a_w1_data;

  logic [P2*AW2-1:0] b_raddr;
  logic [P2*DW2-1:0] b_rdata;
  logic [P2-1:0]     b_rbusy;
  logic              b_w0_en, b_w1_en, b_rsv_en, b_clr_start, b_clr_busy, b_clr_done;
  logic [AW2-1:0]    b_w0_addr, b_w1_addr, b_rsv_addr;
  logic [DW2-1:0]    b_w0_data, b_w1_data;

  cpu_register_file_mp #(
    .DATA_WIDTH(DW), .NUMBER_OF_REGISTERS(N), .NUMBER_OF_READ_PORTS(P)
  ) u_dut_a (
    .clock_in(clk), .reset_in(rst),
    .read_address_in(a_raddr), .read_data_out(a_rdata), .read_busy_out(a_rbusy),
    .write0_enable_in(a_w0_en), .write0_address_in(a_w0_addr), .write0_data_in(a_w0_data),
    .write1_enable_in(a_w1_en), .write1_address_in(a_w1_addr), .write1_data_in(a_w1_data),
    .reserve_enable_in(a_rsv_en), .reserve_address_in(a_rsv_addr),
    .clear_start_in(a_clr_start), .clear_busy_out(a_clr_busy), .clear_done_out(a_clr_done)
  );

  cpu_register_file_mp #(
    .DATA_WIDTH(DW2), .NUMBER_OF_REGISTERS(N2), .NUMBER_OF_READ_PORTS(P2)
  ) u_dut_b (
    .clock_in(clk), .reset_in(rst),
    .read_address_in(b_raddr), .read_data_out(b_rdata), .read_busy_out(b_rbusy),
    .write0_enable_in(b_w0_en), .write0_address_in(b_w0_addr), .write0_data_in(b_w0_data),
    .write1_enable_in(b_w1_en), .write1_address_in(b_w1_addr), .write1_data_in(b_w1_data),
    .reserve_enable_in(b_rsv_en), .reserve_address_in(b_rsv_addr),
    .clear_start_in(b_clr_start), .clear_busy_out(b_clr_busy), .clear_done_out(b_clr_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: register contents, busy flags, and the number of
  // cycles the clear engine still occupies (0 = idle, 1 = done cycle).
  logic [DW-1:0] m_reg  [N];
  logic          m_busy [N];
  int            m_clr_left;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_clr_left = 0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (m_clr_left == 0 && a_w0_en && a_w0_addr == a) return a_w0_data;
    if (m_clr_left == 0 && a_w1_en && a_w1_addr == a) return a_w1_data;
    return m_reg[a];
  endfunction

  task automatic model_clock();
    if (m_clr_left == 0) begin
      if (a_w1_en && a_w1_addr != '0) begin
        m_reg[a_w1_addr]  = a_w1_data;
        m_busy[a_w1_addr] = 1'b0;
      end
      if (a_w0_en && a_w0_addr != '0) begin
        m_reg[a_w0_addr]  = a_w0_data;
        m_busy[a_w0_addr] = 1'b0;
      end
      if (a_rsv_en && a_rsv_addr != '0) m_busy[a_rsv_addr] = 1'b1;
      if (a_clr_start) m_clr_left = N;
    end else begin
      if (m_clr_left > 1) begin
        m_reg[N - m_clr_left + 1]  = '0;
        m_busy[N - m_clr_left + 1] = 1'b0;
      end
      m_clr_left--;
    end
  endtask

  task automatic a_idle();
    a_w0_en = 1'b0; a_w1_en = 1'b0; a_rsv_en = 1'b0; a_clr_start = 1'b0;
    a_w0_addr = '0; a_w1_addr = '0; a_rsv_addr = '0;
    a_w0_data = '0; a_w1_data = '0;
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic step();
    #1;
    for (int p = 0; p < P; p++) begin
      chk($sformatf("rd%0d", p), 32'(a_rdata[p*DW +: DW]), 32'(exp_rd(a_raddr[p*AW +: AW])));
      chk($sformatf("busy%0d", p), 32'(a_rbusy[p]), 32'(m_busy[a_raddr[p*AW +: AW]]));
    end
    chk("clr_busy", 32'(a_clr_busy), 32'(m_clr_left > 0));
    chk("clr_done", 32'(a_clr_done), 32'(m_clr_left == 1));
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic load_all(input logic [DW-1:0] v);
    for (int i = 1; i < N; i += 2) begin
      a_w0_en = 1'b1; a_w0_addr = AW'(i);   a_w0_data = v;
      a_w1_en = (i + 1 < N); a_w1_addr = AW'(i + 1); a_w1_data = v;
      step();
    end
    a_idle();
  endtask

  task automatic run_clear(output int bc, output int dc);
    a_idle();
    a_clr_start = 1'b1;
    step();
    a_clr_start = 1'b0;
    bc = 0;
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      a_raddr   = {AW'(c + 1), AW'(c)};
      a_w0_en   = (c == 3);
      a_w0_addr = AW'(2);
      a_w0_data = 8'h3C;
      #1;
      if (!a_clr_busy) break;
      bc++;
      if (a_clr_done) dc++;
      step();
    end
    a_idle();
  endtask

  int bc, dc;

  initial begin
    rst = 1'b1;
    a_idle();
    a_raddr = '0;
    b_w0_en = 1'b0; b_w1_en = 1'b0; b_rsv_en = 1'b0; b_clr_start = 1'b0;
    b_w0_addr = '0; b_w1_addr = '0; b_rsv_addr = '0;
    b_w0_data = '0; b_w1_data = '0; b_raddr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    a_raddr = {4'd5, 4'd3};
    step();

    // Priority between the two write ports and bypass.
    a_w0_en = 1'b1; a_w0_addr = 4'd3; a_w0_data = 8'h11;
    a_w1_en = 1'b1; a_w1_addr = 4'd3; a_w1_data = 8'h22;
    a_raddr = {4'd1, 4'd3};
    #1 chk("bypass_w0_wins", 32'(a_rdata[7:0]), 32'h11);
    step();
    a_idle();
    #1 chk("stored_r3", 32'(a_rdata[7:0]), 32'h11);
    step();
    a_w0_en = 1'b1; a_w0_addr = 4'd0; a_w0_data = 8'h55;
    a_raddr = {4'd3, 4'd0};
    #1 chk("r0_bypass_zero", 32'(a_rdata[7:0]), 32'h0);
    step();
    a_idle();
    #1 chk("r0_stored_zero", 32'(a_rdata[7:0]), 32'h0);
    step();

    // Scoreboard.
    a_rsv_en = 1'b1; a_rsv_addr = 4'd5;
    a_raddr = {4'd6, 4'd5};
    step();
    a_idle();
    #1 chk("r5_reserved", 32'(a_rbusy[0]), 32'h1);
    step();
    a_w1_en = 1'b1; a_w1_addr = 4'd5; a_w1_data = 8'h7F;
    step();
    a_idle();
    #1 chk("r5_released", 32'(a_rbusy[0]), 32'h0);
    chk("r5_data", 32'(a_rdata[7:0]), 32'h7F);
    step();
    a_rsv_en = 1'b1; a_rsv_addr = 4'd6;
    a_w0_en = 1'b1; a_w0_addr = 4'd6; a_w0_data = 8'h01;
    step();
    a_idle();
    a_raddr = {4'd5, 4'd6};
    #1 chk("r6_data", 32'(a_rdata[7:0]), 32'h01);
    chk("r6_busy", 32'(a_rbusy[0]), 32'h1);
    step();

    // Full clear of a loaded file.
    load_all(8'hA5);
    run_clear(bc, dc);
    chk("clear_cycles", 32'(bc), 32'd16);
    chk("clear_done_pulses", 32'(dc), 32'd1);
    a_raddr = {4'd15, 4'd2};
    #1 chk("r2_write_ignored", 32'(a_rdata[7:0]), 32'h0);
    step();

    // Asynchronous reset in the middle of a clear.
    load_all(8'hA5);
    a_clr_start = 1'b1;
    step();
    a_clr_start = 1'b0;
    for (int c = 0; c < 7; c++) step();
    #2 rst = 1'b1;
    model_reset();
    for (int a = 0; a < N; a++) begin
      a_raddr = {AW'(N - 1 - a), AW'(a)};
      #1;
      chk("rst_rd0", 32'(a_rdata[7:0]), 32'h0);
      chk("rst_rd1", 32'(a_rdata[15:8]), 32'h0);
      chk("rst_busy", 32'(a_rbusy), 32'h0);
      chk("rst_clr_busy", 32'(a_clr_busy), 32'h0);
      chk("rst_clr_done", 32'(a_clr_done), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int c = 0; c < 20; c++) begin
      a_raddr = {AW'(c), AW'(c + 8)};
      #1 if (a_clr_done) dc++;
      step();
    end
    chk("no_done_after_abort", 32'(dc), 32'd0);
    load_all(8'h5A);
    run_clear(bc, dc);
    chk("clear2_cycles", 32'(bc), 32'd16);
    chk("clear2_done_pulses", 32'(dc), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      a_w0_en     = 1'($urandom_range(0, 1));
      a_w0_addr   = AW'($urandom);
      a_w0_data   = DW'($urandom);
      a_w1_en     = 1'($urandom_range(0, 1));
      a_w1_addr   = AW'($urandom);
      a_w1_data   = DW'($urandom);
      a_rsv_en    = 1'($urandom_range(0, 1));
      a_rsv_addr  = AW'($urandom);
      a_clr_start = ($urandom_range(0, 49) == 0);
      a_raddr     = (P*AW)'($urandom);
      step();
    end
    a_idle();

    // Wider instance.
    b_w0_en = 1'b1; b_w0_addr = 5'd31; b_w0_data = 16'h8000;
    b_raddr = {5'd31, 5'd31, 5'd31};
    #1;
    for (int p = 0; p < P2; p++)
      chk($sformatf("b_bypass%0d", p), 32'(b_rdata[p*DW2 +: DW2]), 32'h8000);
    @(posedge clk);
    @(negedge clk);
    b_w0_en = 1'b0;
    #1;
    for (int p = 0; p < P2; p++)
      chk($sformatf("b_stored%0d", p), 32'(b_rdata[p*DW2 +: DW2]), 32'h8000);
    b_clr_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_clr_start = 1'b0;
    bc = 0;
    dc = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (!b_clr_busy) break;
      bc++;
      if (b_clr_done) dc++;
      @(negedge clk);
    end
    chk("b_clear_cycles", 32'(bc), 32'd32);
    chk("b_clear_done_pulses", 32'(dc), 32'd1);
    chk("b_r31_cleared", 32'(b_rdata[DW2-1:0]), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_register_file_mp.md
# cpu_register_file_mp

Parametrised multi-port successor to the CPU register file, sitting between the decode stage (read/reserve) and the ALU and load writeback paths. It provides N combinational read ports with same-cycle write bypass, two prioritised write ports, and a hard-wired zero register. A per-register busy scoreboard is set at issue and cleared at writeback. A sequential clear engine zeroes the file one register per cycle on request.

## Interface

Parameters:
- DATA_WIDTH, 8, register width in bits (signed data).
- NUMBER_OF_REGISTERS, 16, depth; power of two, ≥ 4; AW = $clog2(NUMBER_OF_REGISTERS).
- NUMBER_OF_READ_PORTS, 2, read port count, ≥ 1.

Ports:
- clock_in  in  1  single clock; all state updates on posedge only.
- reset_in  in  1  one clock; reset is asynchronous and active-high.
- read_address_in  in  NUMBER_OF_READ_PORTS*AW  packed read addresses; port p at [p*AW +: AW].
- read_data_out  out  NUMBER_OF_READ_PORTS*DATA_WIDTH  packed read data, combinational.
- read_busy_out  out  NUMBER_OF_READ_PORTS  stored busy bit of each read address, combinational.
- write0_enable_in  in  1  ALU writeback enable (high priority).
- write0_address_in  in  AW  ALU writeback address.
- write0_data_in  in  DATA_WIDTH  ALU writeback data.
- write1_enable_in  in  1  load writeback enable (low priority).
- write1_address_in  in  AW  load writeback address.
- write1_data_in  in  DATA_WIDTH  load writeback data.
- reserve_enable_in  in  1  mark destination busy at issue.
- reserve_address_in  in  AW  destination to reserve.
- clear_start_in  in  1  request a full-file clear.
- clear_busy_out  out  1  high while the clear engine runs.
- clear_done_out  out  1  one-cycle pulse on clear completion.

## Operation

- Register 0: reads return 0, writes and reserves to it are ignored, and its busy bit is always 0.
- Write: at posedge, port k writes when enable=1, address≠0, and the engine is IDLE. If both ports target the same address, port 0 wins and port 1 is dropped. Different addresses both write.
- Read bypass: read data for port p comes from the first match in this order.
  - Address 0 → 0.
  - Valid write0 to that address this cycle → write0_data_in.
  - Valid write1 to that address this cycle → write1_data_in.
  - Otherwise → stored value.
- read_busy_out has no bypass; it shows the stored busy bit.
- Scoreboard:
  - A valid write clears the busy bit of its address.
  - A reserve (address≠0, IDLE) sets it.
  - A reserve and a write to the same address in the same cycle: the data is written and the busy bit ends at 1.
- Clear engine FSM:
  - IDLE: clear_start_in=1 → CLEARING, with index←1.
  - CLEARING: each cycle zero registers[index] and busy[index], then index++. After writing index=NUMBER_OF_REGISTERS-1 → DONE.
  - DONE: one cycle, clear_done_out=1 → IDLE.
- clear_busy_out=1 in CLEARING and DONE.
- While clear_busy_out=1:
  - Write ports and reserve are ignored, and data bypass is disabled.
  - Reads return stored values, so the file may be partially cleared.
  - clear_start_in is ignored.
- Arithmetic: no width conversion; data stored verbatim. The index counter is AW bits wide and never wraps past NUMBER_OF_REGISTERS-1.

## Timing

- Reset (asynchronous, any time, including mid-clear):
  - All registers and busy bits go to 0 and the FSM goes to IDLE.
  - clear_busy_out=0, clear_done_out=0, and read_data_out=0 for every address.
  - The clear is aborted with no done pulse.
- Write latency: the value is visible at stored-read one cycle after the enabling posedge. Through bypass it is visible in the same cycle.
- Reserve latency: read_busy_out rises in the cycle after the reserving posedge.
- Clear: if clear_start_in is sampled at posedge T, then:
  - clear_busy_out rises after T.
  - Register i is zeroed at posedge T+i.
  - clear_done_out is high during the cycle after posedge T+N-1 and drops at T+N.
  - clear_busy_out is therefore high for N cycles in total.
- Writes presented in the same cycle as clear_start_in (IDLE) are still committed.

## Test plan

- Reset then read: assert reset_in mid-cycle with the registers preloaded → all read_data_out=0 and busy=0 immediately, before any clock edge.
- Bypass/priority:
  - Same cycle: write0 r3=0x11 and write1 r3=0x22, with read port 0 at r3 → reads 0x11 that cycle.
  - Next cycle: stored value is 0x11.
  - write to r0=0x55 → r0 still reads 0.
- Scoreboard:
  - reserve r5 → busy 1 next cycle.
  - write1 r5=0x7F → busy 0 next cycle.
  - Same-cycle reserve r6 and write0 r6=0x01 → r6=0x01 and busy=1.
- Clear sequence, N=16, file loaded with 0xA5:
  - Pulse clear_start → clear_busy high for 16 cycles.
  - r1..r15 go to 0 in order.
  - clear_done pulses exactly once.
  - A write to r2 during the clear is ignored (reads 0 after completion).
- Reset mid-clear: assert reset at index 8 → all 0, FSM IDLE, no clear_done pulse. A new clear_start afterwards completes normally.
- Parameter sweep: DATA_WIDTH=16, NUMBER_OF_REGISTERS=32, NUMBER_OF_READ_PORTS=3.
  - Write -32768 to r31 → all three ports addressing r31 read -32768.
  - Clear takes 32 cycles.
